// File: rtl/hack_pkg.sv
// Shared Hack boot-path definitions: loader state encoding and ROM geometry.
package hack_pkg;

  localparam int HACK_ROM_ADDR_W = 15;
  localparam int HACK_WORD_W     = 16;

  localparam logic [2:0] HDR_HI  = 3'd0;
  localparam logic [2:0] HDR_LO  = 3'd1;
  localparam logic [2:0] DATA_HI = 3'd2;
  localparam logic [2:0] DATA_LO = 3'd3;
  localparam logic [2:0] DONE    = 3'd4;
  localparam logic [2:0] ERR     = 3'd5;

  // States in which an idle host link counts towards the timeout.
  function automatic logic is_timed_state(input logic [2:0] st);
    return (st == HDR_LO) || (st == DATA_HI) || (st == DATA_LO);
  endfunction

endpackage

// File: rtl/hack_rom_loader_byte_pair_assembler.sv
// Joins an MSB-first byte pair into one ROM word; the word is valid on the low byte.
module byte_pair_assembler
  import hack_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_clear,
  input  logic                   i_hi_en,
  input  logic                   i_lo_en,
  input  logic [7:0]             i_data,
  output logic [HACK_WORD_W-1:0] o_word,
  output logic                   o_word_valid
);

  logic [7:0] r_hi;

  // High-byte holding register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hi <= 8'h00;
    end else if (i_clear) begin
      r_hi <= 8'h00;
    end else if (i_hi_en) begin
      r_hi <= i_data;
    end else begin
      r_hi <= r_hi;
    end
  end

  assign o_word       = {r_hi, i_data};
  assign o_word_valid = i_lo_en;

endmodule

// File: rtl/hack_rom_loader.sv
// Boot loader: streams a length-prefixed image into the Hack instruction ROM,
// holding the CPU in reset until the whole image is written.
module hack_rom_loader
  import hack_pkg::*;
#(
  parameter int ADDR_W         = HACK_ROM_ADDR_W,
  parameter int MAX_WORDS      = 32768,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  input  logic              reload,
  output logic [ADDR_W-1:0] rom_addr,
  output logic [15:0]       rom_wdata,
  output logic              rom_we,
  output logic              cpu_reset,
  output logic              done,
  output logic              error,
  output logic [15:0]       words_loaded
);

  localparam int TMO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  // ERR is taken on the edge where the idle count would reach TIMEOUT_CYCLES-1.
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 2);

  logic [2:0]              r_state;
  logic [2:0]              w_state_nxt;
  logic [15:0]             r_n;
  logic [15:0]             w_n_full;
  logic [15:0]             w_wl_inc;
  logic [TMO_W-1:0]        r_tmo;
  logic                    w_tmo_hit;
  logic                    w_hi_en;
  logic                    w_lo_en;
  logic                    w_last;
  logic [HACK_WORD_W-1:0]  w_word;
  logic                    w_write;
  logic [ADDR_W-1:0]       r_rom_addr;
  logic [15:0]             r_rom_wdata;
  logic                    r_rom_we;
  logic                    r_cpu_reset;
  logic                    r_done;
  logic                    r_error;
  logic [15:0]             r_words_loaded;

  byte_pair_assembler u_bpa (
    .clk          (clk),
    .reset        (reset),
    .i_clear      (reload),
    .i_hi_en      (w_hi_en),
    .i_lo_en      (w_lo_en),
    .i_data       (rx_data),
    .o_word       (w_word),
    .o_word_valid (w_write)
  );

  // Next-state decode; reload overrides everything including a same-cycle byte.
  always_comb begin
    w_state_nxt = r_state;
    w_hi_en     = 1'b0;
    w_lo_en     = 1'b0;
    w_last      = 1'b0;
    w_tmo_hit   = 1'b0;
    w_n_full    = {r_n[15:8], rx_data};
    w_wl_inc    = r_words_loaded + 16'd1;
    if (!rx_valid && is_timed_state(r_state) && (r_tmo == TMO_LAST)) begin
      w_tmo_hit = 1'b1;
    end else begin
      w_tmo_hit = 1'b0;
    end
    if (reload) begin
      w_state_nxt = HDR_HI;
    end else begin
      case (r_state)
        HDR_HI: begin
          if (rx_valid) w_state_nxt = HDR_LO;
          else          w_state_nxt = HDR_HI;
        end
        HDR_LO: begin
          if (rx_valid) begin
            if (w_n_full == 16'd0)                          w_state_nxt = DONE;
            else if ({16'd0, w_n_full} > 32'(MAX_WORDS))    w_state_nxt = ERR;
            else                                            w_state_nxt = DATA_HI;
          end else if (w_tmo_hit) begin
            w_state_nxt = ERR;
          end else begin
            w_state_nxt = HDR_LO;
          end
        end
        DATA_HI: begin
          if (rx_valid) begin
            w_hi_en     = 1'b1;
            w_state_nxt = DATA_LO;
          end else if (w_tmo_hit) begin
            w_state_nxt = ERR;
          end else begin
            w_state_nxt = DATA_HI;
          end
        end
        DATA_LO: begin
          if (rx_valid) begin
            w_lo_en = 1'b1;
            if (w_wl_inc == r_n) begin
              w_last      = 1'b1;
              w_state_nxt = DONE;
            end else begin
              w_state_nxt = DATA_HI;
            end
          end else if (w_tmo_hit) begin
            w_state_nxt = ERR;
          end else begin
            w_state_nxt = DATA_LO;
          end
        end
        DONE:    w_state_nxt = DONE;
        ERR:     w_state_nxt = ERR;
        default: w_state_nxt = HDR_HI;
      endcase
    end
  end

  // State, header length, idle counter and word counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state        <= HDR_HI;
      r_n            <= 16'd0;
      r_tmo          <= '0;
      r_words_loaded <= 16'd0;
    end else begin
      r_state <= w_state_nxt;
      if (reload) begin
        r_n <= 16'd0;
      end else if (rx_valid && (r_state == HDR_HI)) begin
        r_n[15:8] <= rx_data;
      end else if (rx_valid && (r_state == HDR_LO)) begin
        r_n <= w_n_full;
      end else begin
        r_n <= r_n;
      end
      if (reload || rx_valid || (w_state_nxt != r_state)) begin
        r_tmo <= '0;
      end else if (is_timed_state(r_state)) begin
        r_tmo <= r_tmo + {{(TMO_W-1){1'b0}}, 1'b1};
      end else begin
        r_tmo <= r_tmo;
      end
      if (reload) begin
        r_words_loaded <= 16'd0;
      end else if (w_write) begin
        r_words_loaded <= w_wl_inc;
      end else begin
        r_words_loaded <= r_words_loaded;
      end
    end
  end

  // Registered ROM port and status; cpu_reset stays high through the last write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rom_addr  <= '0;
      r_rom_wdata <= 16'd0;
      r_rom_we    <= 1'b0;
      r_cpu_reset <= 1'b1;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
    end else begin
      r_rom_we <= w_write;
      if (w_write) begin
        r_rom_addr  <= r_words_loaded[ADDR_W-1:0];
        r_rom_wdata <= w_word;
      end else begin
        r_rom_addr  <= r_rom_addr;
        r_rom_wdata <= r_rom_wdata;
      end
      r_cpu_reset <= (w_state_nxt != DONE) || w_last;
      r_done      <= (w_state_nxt == DONE);
      r_error     <= (w_state_nxt == ERR);
    end
  end

  assign rom_addr     = r_rom_addr;
  assign rom_wdata    = r_rom_wdata;
  assign rom_we       = r_rom_we;
  assign cpu_reset    = r_cpu_reset;
  assign done         = r_done;
  assign error        = r_error;
  assign words_loaded = r_words_loaded;

endmodule

// File: tb/tb_hack_rom_loader.sv
// Directed bench for hack_rom_loader: per-cycle vector table plus timeout and async-reset sequences.
module tb_hack_rom_loader;

  logic        clk;
  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        reload;
  logic [14:0] rom_addr;
  logic [15:0] rom_wdata;
  logic        rom_we;
  logic        cpu_reset;
  logic        done;
  logic        error;
  logic [15:0] words_loaded;

  int n_tests;
  int n_fail;

  hack_rom_loader #(
    .ADDR_W         (15),
    .MAX_WORDS      (32768),
    .TIMEOUT_CYCLES (100)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .reload       (reload),
    .rom_addr     (rom_addr),
    .rom_wdata    (rom_wdata),
    .rom_we       (rom_we),
    .cpu_reset    (cpu_reset),
    .done         (done),
    .error        (error),
    .words_loaded (words_loaded)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [7:0]  d;
    logic        rl;
    logic        we;
    logic [14:0] addr;
    logic [15:0] wd;
    logic        cr;
    logic        dn;
    logic        er;
    logic [15:0] wl;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic v, input logic [7:0] d, input logic rl,
                              input logic we, input logic [14:0] addr, input logic [15:0] wd,
                              input logic cr, input logic dn, input logic er, input logic [15:0] wl);
    vec_t r;
    r.v = v; r.d = d; r.rl = rl; r.we = we; r.addr = addr; r.wd = wd;
    r.cr = cr; r.dn = dn; r.er = er; r.wl = wl;
    return r;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic pulse_reload();
    @(negedge clk);
    reload = 1'b1;
    @(negedge clk);
    reload = 1'b0;
  endtask

  initial begin
    int first_err;
    int we_seen;
    n_tests  = 0;
    n_fail   = 0;
    reset    = 1'b1;
    rx_data  = 8'h00;
    rx_valid = 1'b0;
    reload   = 1'b0;

    // Nominal three-word load, then a byte ignored in DONE, then reload racing a byte.
    tbl.push_back(mk(1'b1, 8'h00, 1'b0, 1'b0, 15'd0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'd0));
    tbl.push_back(mk(1'b1, 8'h03, 1'b0, 1'b0, 15'd0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'd0));
    tbl.push_back(mk(1'b1, 8'h12, 1'b0, 1'b0, 15'd0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'd0));
    tbl.push_back(mk(1'b1, 8'h34, 1'b0, 1'b1, 15'd0, 16'h1234, 1'b1, 1'b0, 1'b0, 16'd1));
    tbl.push_back(mk(1'b0, 8'h00, 1'b0, 1'b0, 15'd0, 16'h1234, 1'b1, 1'b0, 1'b0, 16'd1));
    tbl.push_back(mk(1'b1, 8'hAB, 1'b0, 1'b0, 15'd0, 16'h1234, 1'b1, 1'b0, 1'b0, 16'd1));
    tbl.push_back(mk(1'b1, 8'hCD, 1'b0, 1'b1, 15'd1, 16'hABCD, 1'b1, 1'b0, 1'b0, 16'd2));
    tbl.push_back(mk(1'b1, 8'h7F, 1'b0, 1'b0, 15'd1, 16'hABCD, 1'b1, 1'b0, 1'b0, 16'd2));
    tbl.push_back(mk(1'b1, 8'hFF, 1'b0, 1'b1, 15'd2, 16'h7FFF, 1'b1, 1'b1, 1'b0, 16'd3));
    tbl.push_back(mk(1'b0, 8'h00, 1'b0, 1'b0, 15'd2, 16'h7FFF, 1'b0, 1'b1, 1'b0, 16'd3));
    tbl.push_back(mk(1'b1, 8'h55, 1'b0, 1'b0, 15'd2, 16'h7FFF, 1'b0, 1'b1, 1'b0, 16'd3));
    tbl.push_back(mk(1'b1, 8'h00, 1'b1, 1'b0, 15'd2, 16'h7FFF, 1'b1, 1'b0, 1'b0, 16'd0));
    // Empty image.
    tbl.push_back(mk(1'b1, 8'h00, 1'b0, 1'b0, 15'd2, 16'h7FFF, 1'b1, 1'b0, 1'b0, 16'd0));
    tbl.push_back(mk(1'b1, 8'h00, 1'b0, 1'b0, 15'd2, 16'h7FFF, 1'b0, 1'b1, 1'b0, 16'd0));
    tbl.push_back(mk(1'b0, 8'h00, 1'b1, 1'b0, 15'd2, 16'h7FFF, 1'b1, 1'b0, 1'b0, 16'd0));
    // Oversize header, bytes ignored in ERR, reload clears error.
    tbl.push_back(mk(1'b1, 8'h80, 1'b0, 1'b0, 15'd2, 16'h7FFF, 1'b1, 1'b0, 1'b0, 16'd0));
    tbl.push_back(mk(1'b1, 8'h01, 1'b0, 1'b0, 15'd2, 16'h7FFF, 1'b1, 1'b0, 1'b1, 16'd0));
    tbl.push_back(mk(1'b1, 8'h12, 1'b0, 1'b0, 15'd2, 16'h7FFF, 1'b1, 1'b0, 1'b1, 16'd0));
    tbl.push_back(mk(1'b1, 8'h34, 1'b0, 1'b0, 15'd2, 16'h7FFF, 1'b1, 1'b0, 1'b1, 16'd0));
    tbl.push_back(mk(1'b0, 8'h00, 1'b1, 1'b0, 15'd2, 16'h7FFF, 1'b1, 1'b0, 1'b0, 16'd0));
    // Reach DONE, then reload with a same-cycle byte that must be dropped.
    tbl.push_back(mk(1'b1, 8'h00, 1'b0, 1'b0, 15'd2, 16'h7FFF, 1'b1, 1'b0, 1'b0, 16'd0));
    tbl.push_back(mk(1'b1, 8'h00, 1'b0, 1'b0, 15'd2, 16'h7FFF, 1'b0, 1'b1, 1'b0, 16'd0));
    tbl.push_back(mk(1'b1, 8'h00, 1'b1, 1'b0, 15'd2, 16'h7FFF, 1'b1, 1'b0, 1'b0, 16'd0));
    tbl.push_back(mk(1'b1, 8'h00, 1'b0, 1'b0, 15'd2, 16'h7FFF, 1'b1, 1'b0, 1'b0, 16'd0));
    tbl.push_back(mk(1'b1, 8'h01, 1'b0, 1'b0, 15'd2, 16'h7FFF, 1'b1, 1'b0, 1'b0, 16'd0));
    tbl.push_back(mk(1'b1, 8'hBE, 1'b0, 1'b0, 15'd2, 16'h7FFF, 1'b1, 1'b0, 1'b0, 16'd0));
    tbl.push_back(mk(1'b1, 8'hEF, 1'b0, 1'b1, 15'd0, 16'hBEEF, 1'b1, 1'b1, 1'b0, 16'd1));
    tbl.push_back(mk(1'b0, 8'h00, 1'b0, 1'b0, 15'd0, 16'hBEEF, 1'b0, 1'b1, 1'b0, 16'd1));
    // N equal to MAX_WORDS is legal.
    tbl.push_back(mk(1'b0, 8'h00, 1'b1, 1'b0, 15'd0, 16'hBEEF, 1'b1, 1'b0, 1'b0, 16'd0));
    tbl.push_back(mk(1'b1, 8'h80, 1'b0, 1'b0, 15'd0, 16'hBEEF, 1'b1, 1'b0, 1'b0, 16'd0));
    tbl.push_back(mk(1'b1, 8'h00, 1'b0, 1'b0, 15'd0, 16'hBEEF, 1'b1, 1'b0, 1'b0, 16'd0));
    tbl.push_back(mk(1'b0, 8'h00, 1'b1, 1'b0, 15'd0, 16'hBEEF, 1'b1, 1'b0, 1'b0, 16'd0));

    repeat (3) @(negedge clk);
    check("rst.rom_we",       {31'd0, rom_we},    32'd0);
    check("rst.rom_addr",     {17'd0, rom_addr},  32'd0);
    check("rst.rom_wdata",    {16'd0, rom_wdata}, 32'd0);
    check("rst.cpu_reset",    {31'd0, cpu_reset}, 32'd1);
    check("rst.done",         {31'd0, done},      32'd0);
    check("rst.error",        {31'd0, error},     32'd0);
    check("rst.words_loaded", {16'd0, words_loaded}, 32'd0);
    reset = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      rx_valid = tbl[i].v;
      rx_data  = tbl[i].d;
      reload   = tbl[i].rl;
      @(negedge clk);
      check($sformatf("row%0d.rom_we", i),    {31'd0, rom_we},       {31'd0, tbl[i].we});
      check($sformatf("row%0d.rom_addr", i),  {17'd0, rom_addr},     {17'd0, tbl[i].addr});
      check($sformatf("row%0d.rom_wdata", i), {16'd0, rom_wdata},    {16'd0, tbl[i].wd});
      check($sformatf("row%0d.cpu_reset", i), {31'd0, cpu_reset},    {31'd0, tbl[i].cr});
      check($sformatf("row%0d.done", i),      {31'd0, done},         {31'd0, tbl[i].dn});
      check($sformatf("row%0d.error", i),     {31'd0, error},        {31'd0, tbl[i].er});
      check($sformatf("row%0d.words", i),     {16'd0, words_loaded}, {16'd0, tbl[i].wl});
    end
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    reload   = 1'b0;

    // Timeout: error must appear on exactly the 99th idle edge after the 0x33 byte.
    pulse_reload();
    send_byte(8'h00);
    send_byte(8'h02);
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    check("tmo.words_before", {16'd0, words_loaded}, 32'd1);
    first_err = 0;
    for (int i = 1; i <= 120; i++) begin
      @(negedge clk);
      if (error && (first_err == 0)) first_err = i;
    end
    check("tmo.idle_cycles",  first_err, 32'd99);
    check("tmo.words_after",  {16'd0, words_loaded}, 32'd1);
    check("tmo.cpu_reset",    {31'd0, cpu_reset}, 32'd1);
    check("tmo.done",         {31'd0, done},      32'd0);

    // Asynchronous reset between the high and low byte of word 2.
    pulse_reload();
    send_byte(8'h00);
    send_byte(8'h02);
    send_byte(8'h12);
    send_byte(8'h34);
    send_byte(8'h56);
    check("arst.pre_words", {16'd0, words_loaded}, 32'd1);
    check("arst.pre_wdata", {16'd0, rom_wdata},    32'h1234);
    #2;
    reset = 1'b1;
    #1;
    check("arst.words",     {16'd0, words_loaded}, 32'd0);
    check("arst.wdata",     {16'd0, rom_wdata},    32'd0);
    check("arst.cpu_reset", {31'd0, cpu_reset},    32'd1);
    check("arst.rom_we",    {31'd0, rom_we},       32'd0);
    we_seen = 0;
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = 8'h78;
    @(negedge clk);
    if (rom_we) we_seen++;
    rx_valid = 1'b0;
    reset    = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (rom_we) we_seen++;
    end
    check("arst.no_we", we_seen, 32'd0);
    send_byte(8'h00);
    send_byte(8'h00);
    check("arst.fresh_hdr_done", {31'd0, done}, 32'd1);
    check("arst.fresh_cpu_rst",  {31'd0, cpu_reset}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
